// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
// Optional signed-overflow output is enabled by defining SERSUB_OVF_EN.
package serial_sub_pkg;

  localparam int unsigned DefWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DefCntWidth = $clog2(DefWidth);

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bo = borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B ^ Bin;
  assign Bo = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single full subtractor.
// Define SERSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] d_sh_q;
  logic             brw_q;
  logic             fs_d;
  logic             fs_bo;
`ifdef SERSUB_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  full_subtractor u_fs (
    .A   (a_sh_q[0]),
    .B   (b_sh_q[0]),
    .Bin (brw_q),
    .D   (fs_d),
    .Bo  (fs_bo)
  );

  // Result registers (diff/bout/ovf/done) are loaded from the DONE state, so the
  // visible result trails the last processed bit by one edge and stays put until
  // the next completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
`ifdef SERSUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end
        end
        StShift: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          d_sh_q <= {fs_d, d_sh_q[WIDTH-1:1]};
          brw_q  <= fs_bo;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b1;
          diff    <= d_sh_q;
          bout    <= brw_q;
          state_q <= StIdle;
`ifdef SERSUB_OVF_EN
          ovf     <= (a_msb_q != b_msb_q) && (d_sh_q[WIDTH-1] != a_msb_q);
`endif
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed corner cases plus random operands
// against an arithmetic reference model. Honours SERSUB_OVF_EN for the ovf output.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Reference model: plain integer arithmetic on the operands.
  function automatic int m_diff(input int x, input int y, input int c);
    return (x - y - c) & ((1 << W) - 1);
  endfunction

  function automatic int m_bout(input int x, input int y, input int c);
    return ((x - y - c) < 0) ? 1 : 0;
  endfunction

  function automatic int m_ovf(input int x, input int y, input int c);
    int sx, sy, r;
    sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
    r  = sx - sy - c;
    return (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'($urandom);
  endtask

  // Drives one start now (caller is away from an edge), then waits for done.
  // poke_at > 0 re-pulses start with junk operands just before SHIFT edge poke_at.
  task automatic run_op(input string tag, input int x, input int y, input int c,
                        input int poke_at);
    int lat;
    lat   = 0;
    a     = W'(x);
    b     = W'(y);
    bin   = c[0];
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_early_done"}, int'(done), 0);
    start = 1'b0;
    scramble();
    for (int k = 1; k <= int'(W) + 4 && lat == 0; k++) begin
      if (k == poke_at) begin
        start = 1'b1;
        scramble();
      end
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      if (done) lat = k;
    end
    check({tag, "_latency"}, lat, int'(W) + 1);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_diff"}, int'(diff), m_diff(x, y, c));
    check({tag, "_bout"}, int'(bout), m_bout(x, y, c));
`ifdef SERSUB_OVF_EN
    check({tag, "_ovf"}, int'(ovf), m_ovf(x, y, c));
`endif
  endtask

  // Watches n edges with start low; done must never rise.
  task automatic quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      scramble();
      if (done) pulses++;
    end
    check({tag, "_extra_done"}, pulses, 0);
  endtask

  initial begin
    int x, y, c;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_diff", int'(diff), 0);
    check("reset_bout", int'(bout), 0);
`ifdef SERSUB_OVF_EN
    check("reset_ovf", int'(ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset release accepts start.
    run_op("sub_05_03", 'h05, 'h03, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      scramble();
    end
    check("hold_diff", int'(diff), 'h02);
    check("hold_bout", int'(bout), 0);
    check("hold_done", int'(done), 0);

    @(negedge clk);
    run_op("sub_00_01", 'h00, 'h01, 0, 0);
    @(negedge clk);
    run_op("sub_10_0f_b", 'h10, 'h0F, 1, 0);
    @(negedge clk);
    run_op("sub_80_01", 'h80, 'h01, 0, 0);
    @(negedge clk);
    run_op("sub_05_03_b", 'h05, 'h03, 0, 0);

    // Start re-pulsed during SHIFT must be ignored and not queued.
    @(negedge clk);
    run_op("poke", 'h37, 'h12, 0, 3);
    quiet("poke", int'(W) + 4);

    // Asynchronous reset in mid-SHIFT.
    @(negedge clk);
    a     = 8'h5A;
    b     = 8'h33;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(bout), 0);
`ifdef SERSUB_OVF_EN
    check("midrst_ovf", int'(ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    quiet("midrst", int'(W) + 4);
    @(negedge clk);
    run_op("after_rst", 'hC4, 'h3B, 1, 0);

    // Back-to-back: second start sampled on the edge right after the done cycle begins.
    @(negedge clk);
    run_op("b2b_first", 'h05, 'h03, 0, 0);
    run_op("b2b_second", 'hFF, 'hFF, 0, 0);

    // Random operands, mixing back-to-back and gapped issue.
    for (int n = 0; n < 16; n++) begin
      x = int'($urandom_range(0, (1 << W) - 1));
      y = int'($urandom_range(0, (1 << W) - 1));
      c = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op($sformatf("rand%0d", n), x, y, c, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
